// File: rtl/screen_sequencer_pkg.sv
// Shared types and constants for the poker display screen sequencer.
//   screen_e : renderer select codes driven on screen_sel
//   state_e  : sequencer FSM states (also exported for debug)
//   KEY_ENTER, BRIGHT_W, BRIGHT_FULL : key code and brightness constants
//   sat_sub  : saturating brightness decrement
package screen_pkg;

   typedef enum logic [1:0] {
      SCR_START  = 2'd0,
      SCR_GAME   = 2'd1,
      SCR_RESULT = 2'd2
   } screen_e;

   typedef enum logic [1:0] {
      S_START,
      S_FADE,
      S_GAME,
      S_RESULT
   } state_e;

   localparam logic [7:0] KEY_ENTER = 8'h28;

   localparam int BRIGHT_W = 4;
   localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = '1;

   // Brightness minus step, clamped at zero (never wraps to a bright value).
   function automatic logic [BRIGHT_W-1:0] sat_sub(input logic [BRIGHT_W-1:0] level,
                                                   input logic [31:0]         step);
      logic [31:0] level_32;
      level_32 = {{(32-BRIGHT_W){1'b0}}, level};
      if (step >= level_32) begin
         return '0;
      end
      return level - step[BRIGHT_W-1:0];
   endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle between the keyboard/VGA side and the screen sequencer.
//   Inputs to the sequencer : keycode, frame_start, game_over
//   Outputs from sequencer  : screen_sel, brightness, blink_on, new_game, state
// Signalling: there is no valid/ready pair here. keycode and game_over are
// levels sampled every cycle; frame_start and new_game are single-cycle
// pulses that are acted on in the cycle they are high; all sequencer outputs
// are registered and change one cycle after the frame_start that causes them.
// state is a debug view of the sequencer FSM.
interface screen_sequencer_if;
   import screen_pkg::*;

   logic [7:0]          keycode;
   logic                frame_start;
   logic                game_over;
   screen_e             screen_sel;
   logic [BRIGHT_W-1:0] brightness;
   logic                blink_on;
   logic                new_game;
   state_e              state;

   modport master (
      output keycode, frame_start, game_over,
      input  screen_sel, brightness, blink_on, new_game, state
   );

   modport slave (
      input  keycode, frame_start, game_over,
      output screen_sel, brightness, blink_on, new_game, state
   );

endinterface

// File: rtl/screen_sequencer_key_edge_detect.sv
// Single-key press detector on a USB HID keycode stream.
//   clk, reset : clock and synchronous active-high reset
//   keycode    : current keycode (0 = no key)
//   match_code : keycode to detect
//   press      : high for the one cycle the key goes from absent to present
// The previous keycode is registered every cycle regardless of what the
// consumer is doing, so a key held across any period yields one press only.
module key_edge_detect (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] keycode,
   input  logic [7:0] match_code,
   output logic       press
);

   logic [7:0] key_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         key_prev <= '0;
      end else begin
         key_prev <= keycode;
      end
   end

   assign press = (keycode == match_code) && (key_prev != match_code);

endmodule

// File: rtl/screen_sequencer.sv
// Screen controller: START -> FADE -> GAME -> RESULT -> START.
//   Clk, Reset : clock and synchronous active-high reset
//   bus        : slave side of screen_sequencer_if
//                (keycode, frame_start, game_over in;
//                 screen_sel, brightness, blink_on, new_game, state out)
// Parameters: ENTER_CODE (key that advances), BLINK_FRAMES (frames per
// prompt blink half-period, >= 1), FADE_STEP (brightness drop per frame, >= 1).
// Screen changes happen only on frame_start so a frame is never torn.
module screen_sequencer
   import screen_pkg::*;
#(
   parameter logic [7:0] ENTER_CODE   = KEY_ENTER,
   parameter int         BLINK_FRAMES = 30,
   parameter int         FADE_STEP    = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   screen_sequencer_if.slave bus
);

   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
   localparam logic [31:0]        STEP_32    = 32'(FADE_STEP);

   logic enter_edge;

   key_edge_detect u_enter (
      .clk        (Clk),
      .reset      (Reset),
      .keycode    (bus.keycode),
      .match_code (ENTER_CODE),
      .press      (enter_edge)
   );

   state_e              state_q,     state_d;
   screen_e             sel_q,       sel_d;
   logic [BRIGHT_W-1:0] bright_q,    bright_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic                blink_on_q,  blink_on_d;
   logic                new_game_q,  new_game_d;
   logic                pending_q,   pending_d;

   logic                trig;
   logic                blink_wrap;
   logic [BLINK_W-1:0]  blink_cnt_inc;
   logic                blink_on_inc;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_START;
         sel_q       <= SCR_START;
         bright_q    <= BRIGHT_FULL;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         new_game_q  <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         bright_q    <= bright_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         new_game_q  <= new_game_d;
         pending_q   <= pending_d;
      end
   end

   // An ENTER press seen mid-frame is held until the next frame_start; a
   // press landing on the frame_start cycle itself counts immediately.
   assign trig = pending_q || enter_edge;

   // Blink advance applied on a frame_start that does not leave the screen.
   assign blink_wrap    = (blink_cnt_q == BLINK_LAST);
   assign blink_cnt_inc = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
   assign blink_on_inc  = blink_wrap ? ~blink_on_q : blink_on_q;

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      bright_d    = bright_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      new_game_d  = 1'b0;
      pending_d   = pending_q;

      // Every transition happens on frame_start, so clearing here also
      // covers clearing on state entry. Presses are latched only on screens
      // that wait for ENTER.
      if (bus.frame_start) begin
         pending_d = 1'b0;
      end else if (enter_edge && (state_q == S_START || state_q == S_RESULT)) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         S_START: begin
            if (bus.frame_start) begin
               if (trig) begin
                  state_d  = S_FADE;
                  bright_d = sat_sub(BRIGHT_FULL, STEP_32);
               end else begin
                  blink_cnt_d = blink_cnt_inc;
                  blink_on_d  = blink_on_inc;
               end
            end
         end
         S_FADE: begin
            // The black frame is shown once before the game screen appears.
            if (bus.frame_start) begin
               if (bright_q == '0) begin
                  state_d    = S_GAME;
                  sel_d      = SCR_GAME;
                  bright_d   = BRIGHT_FULL;
                  blink_on_d = 1'b1;
                  new_game_d = 1'b1;
               end else begin
                  bright_d = sat_sub(bright_q, STEP_32);
               end
            end
         end
         S_GAME: begin
            if (bus.frame_start && bus.game_over) begin
               state_d     = S_RESULT;
               sel_d       = SCR_RESULT;
               blink_cnt_d = '0;
               blink_on_d  = 1'b1;
            end
         end
         S_RESULT: begin
            if (bus.frame_start) begin
               if (trig) begin
                  state_d     = S_START;
                  sel_d       = SCR_START;
                  blink_cnt_d = '0;
                  blink_on_d  = 1'b1;
               end else begin
                  blink_cnt_d = blink_cnt_inc;
                  blink_on_d  = blink_on_inc;
               end
            end
         end
         default: begin
            state_d = S_START;
            sel_d   = SCR_START;
         end
      endcase
   end

   assign bus.screen_sel = sel_q;
   assign bus.brightness = bright_q;
   assign bus.blink_on   = blink_on_q;
   assign bus.new_game   = new_game_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed walk through every screen with
// literal expectations, then randomized keys/frames/game_over/reset checked
// each cycle against a frame-counting reference model.
module tb_screen_sequencer;
   import screen_pkg::*;

   localparam int BLINK = 2;
   localparam int STEP  = 5;
   localparam logic [7:0] ENTER = 8'h28;

   logic clk = 1'b0;
   logic rst = 1'b1;

   screen_sequencer_if sif ();

   screen_sequencer #(
      .ENTER_CODE   (ENTER),
      .BLINK_FRAMES (BLINK),
      .FADE_STEP    (STEP)
   ) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (sif.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Screen is tracked by name; blink is derived from the number of frames
   // shown on the current screen; brightness from frames spent fading.
   state_e m_scr    = S_START;
   int     m_frames = 0;
   int     m_fade_n = 0;
   int     m_bright = 15;
   int     m_blink  = 1;
   int     m_newg   = 0;
   bit     m_pend   = 0;
   logic [7:0] m_prev = 8'h00;
   bit     m_valid  = 0;

   function automatic int clamp0(input int v);
      return (v < 0) ? 0 : v;
   endfunction

   function automatic int sel_of(input state_e s);
      if (s == S_GAME)   return 1;
      if (s == S_RESULT) return 2;
      return 0;
   endfunction

   always @(posedge clk) begin
      bit press;
      bit fs;
      m_valid = 1;
      if (rst) begin
         m_scr = S_START; m_frames = 0; m_fade_n = 0; m_bright = 15;
         m_blink = 1; m_newg = 0; m_pend = 0; m_prev = 8'h00;
      end else begin
         fs     = sif.frame_start;
         press  = (sif.keycode == ENTER) && (m_prev != ENTER);
         m_prev = sif.keycode;
         m_newg = 0;
         case (m_scr)
            S_START, S_RESULT: begin
               if (fs && (m_pend || press)) begin
                  if (m_scr == S_START) begin
                     m_scr = S_FADE; m_fade_n = 1; m_bright = clamp0(15 - STEP);
                  end else begin
                     m_scr = S_START; m_frames = 0; m_blink = 1;
                  end
               end else if (fs) begin
                  m_frames++;
                  m_blink = ((m_frames / BLINK) % 2 == 0) ? 1 : 0;
               end
               if (fs) m_pend = 0;
               else if (press) m_pend = 1;
            end
            S_FADE: begin
               if (fs) begin
                  if (m_bright == 0) begin
                     m_scr = S_GAME; m_bright = 15; m_newg = 1; m_blink = 1;
                  end else begin
                     m_fade_n++;
                     m_bright = clamp0(15 - STEP * m_fade_n);
                  end
               end
            end
            default: begin
               if (fs && sif.game_over) begin
                  m_scr = S_RESULT; m_frames = 0; m_blink = 1;
               end
            end
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         chk("screen_sel", 32'(sif.screen_sel), 32'(sel_of(m_scr)));
         chk("brightness", 32'(sif.brightness), 32'(m_bright));
         chk("new_game",   32'(sif.new_game),   32'(m_newg));
         chk("state",      32'(sif.state),      32'(m_scr));
         if (m_scr != S_FADE) chk("blink_on", 32'(sif.blink_on), 32'(m_blink));
         chk("sel_not_3", 32'(sif.screen_sel == 2'd3), 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse frame_start for one cycle; returns at the negedge where the
   // resulting outputs are visible.
   task automatic pulse_frame();
      @(negedge clk);
      sif.frame_start = 1'b1;
      @(negedge clk);
      sif.frame_start = 1'b0;
   endtask

   task automatic tap_enter();
      @(negedge clk);
      sif.keycode = ENTER;
      idle(2);
      sif.keycode = 8'h00;
      idle(2);
   endtask

   task automatic lit(input string name, input logic [31:0] act, input int exp);
      chk(name, act, 32'(exp));
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int blink_exp [4] = '{1, 0, 0, 1};
      sif.keycode = 8'h00;
      sif.frame_start = 1'b0;
      sif.game_over = 1'b0;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      lit("rst_sel", 32'(sif.screen_sel), 0);
      lit("rst_bright", 32'(sif.brightness), 15);
      lit("rst_blink", 32'(sif.blink_on), 1);
      lit("rst_newg", 32'(sif.new_game), 0);

      // Blink in START, toggling every BLINK frames.
      for (int i = 0; i < 4; i++) begin
         idle(5);
         pulse_frame();
         lit($sformatf("blink_%0d", i), 32'(sif.blink_on), blink_exp[i]);
         lit($sformatf("model_blink_%0d", i), 32'(m_blink), blink_exp[i]);
         lit("start_sel", 32'(sif.screen_sel), 0);
      end

      // ENTER held 100 cycles mid-frame, still held through the fade.
      @(negedge clk);
      sif.keycode = ENTER;
      idle(100);
      lit("held_no_change", 32'(sif.screen_sel), 0);
      pulse_frame();
      lit("fade_10", 32'(sif.brightness), 10);
      lit("model_fade_10", 32'(m_bright), 10);
      pulse_frame();
      lit("fade_5", 32'(sif.brightness), 5);
      pulse_frame();
      lit("fade_0", 32'(sif.brightness), 0);
      lit("fade_sel", 32'(sif.screen_sel), 0);
      pulse_frame();
      lit("game_sel", 32'(sif.screen_sel), 1);
      lit("game_bright", 32'(sif.brightness), 15);
      lit("game_newg", 32'(sif.new_game), 1);
      @(negedge clk);
      lit("newg_once", 32'(sif.new_game), 0);
      idle(3);
      pulse_frame();
      lit("held_no_retrig", 32'(sif.screen_sel), 1);
      sif.keycode = 8'h00;

      // ENTER in GAME is ignored and not carried into RESULT.
      tap_enter();
      pulse_frame();
      lit("game_ignore_enter", 32'(sif.screen_sel), 1);
      tap_enter();
      sif.game_over = 1'b1;
      pulse_frame();
      lit("result_sel", 32'(sif.screen_sel), 2);
      sif.game_over = 1'b0;
      idle(3);
      pulse_frame();
      lit("no_pending_carry", 32'(sif.screen_sel), 2);

      // ENTER edge on the frame_start cycle in RESULT.
      idle(3);
      @(negedge clk);
      sif.keycode = ENTER;
      sif.frame_start = 1'b1;
      @(negedge clk);
      sif.frame_start = 1'b0;
      lit("coincident_sel", 32'(sif.screen_sel), 0);
      lit("coincident_blink", 32'(sif.blink_on), 1);
      sif.keycode = 8'h00;

      // game_over during FADE is ignored; acted on once in GAME.
      tap_enter();
      pulse_frame();
      lit("fade2_10", 32'(sif.brightness), 10);
      sif.game_over = 1'b1;
      pulse_frame();
      pulse_frame();
      lit("fade2_0", 32'(sif.brightness), 0);
      lit("fade2_sel", 32'(sif.screen_sel), 0);
      pulse_frame();
      lit("game2_sel", 32'(sif.screen_sel), 1);
      pulse_frame();
      lit("result2_sel", 32'(sif.screen_sel), 2);
      sif.game_over = 1'b0;

      // Reset in the middle of a fade.
      tap_enter();
      pulse_frame();
      lit("back_start", 32'(sif.screen_sel), 0);
      tap_enter();
      pulse_frame();
      pulse_frame();
      lit("pre_rst_5", 32'(sif.brightness), 5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lit("midrst_sel", 32'(sif.screen_sel), 0);
      lit("midrst_bright", 32'(sif.brightness), 15);
      lit("midrst_blink", 32'(sif.blink_on), 1);
      tap_enter();
      pulse_frame();
      lit("fresh_fade", 32'(sif.brightness), 10);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 699) == 0);
         sif.frame_start = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0: sif.keycode = 8'h00;
               1: sif.keycode = ENTER;
               default: sif.keycode = 8'h04;
            endcase
         end
         if ($urandom_range(0, 24) == 0) sif.game_over = ~sif.game_over;
      end
      @(negedge clk);
      rst = 1'b0;
      sif.frame_start = 1'b0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
